// File: rtl/mux_4to1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_4to1_rr_arbiter
// Round-robin arbiter that owns the select of a 4-to-1 data mux. It grants one
// requester at a time for a burst of at most BURST_LEN accepted transfers and
// presents the selected data on a valid/ready output channel. On the edge that
// ends a grant it re-arbitrates immediately, so consecutive grants have no
// idle bubble. The releasing requester gets the lowest priority.
// ----------------------------------------------------------------------------
module mux_4to1_rr_arbiter #(
   parameter int WIDTH     = 4,
   parameter int BURST_LEN = 4    // legal range 1..16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             out_ready,
   output logic [3:0]       gnt,
   output logic [3:0]       ack,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             busy
);

   // Burst counter only has to reach BURST_LEN-1, which is at most 15.
   localparam int CNT_W = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t           r_state;
   logic [1:0]       r_sel;
   logic [1:0]       r_last;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_gnt;
   logic             r_busy;

   logic             w_cur_req;
   logic             w_valid;
   logic             w_xfer;
   logic             w_last_beat;
   logic             w_exit;
   logic [2:0]       w_idle_pick;
   logic [2:0]       w_grant_pick;

   // Round-robin search: first set bit of i_vec at i_start, i_start+1, ...
   // (mod 4). Returns {found, index}.
   function automatic logic [2:0] f_rr_pick(input logic [3:0] i_vec,
                                            input logic [1:0] i_start);
      logic [2:0] v_res;
      logic [1:0] v_idx;
      v_res = 3'b000;
      // Walk from the farthest offset down so the nearest hit is kept.
      for (int i = 3; i >= 0; i--) begin
         v_idx = i_start + 2'(i);
         if (i_vec[v_idx]) begin
            v_res = {1'b1, v_idx};
         end
      end
      return v_res;
   endfunction

   // Transfer and grant-exit qualification from the registered select.
   assign w_cur_req    = req[r_sel];
   assign w_valid      = r_busy & w_cur_req;
   assign w_xfer       = w_valid & out_ready;
   assign w_last_beat  = (r_cnt == CNT_W'(BURST_LEN - 1));
   assign w_exit       = ~w_cur_req | (w_xfer & w_last_beat);

   // Candidate winners: from IDLE the search follows the last winner; on a
   // grant exit it follows the current holder, making the holder lowest.
   assign w_idle_pick  = f_rr_pick(req, r_last + 2'd1);
   assign w_grant_pick = f_rr_pick(req, r_sel + 2'd1);

   // Data mux, forced to zero while idle.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      out = '0;
      if (r_busy) begin
         unique case (r_sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
         endcase
      end
   end

   // Acknowledge goes only to the granted requester on an accepted transfer.
   always_comb begin
      ack = 4'b0000;
      if (w_xfer) begin
         ack = 4'b0001 << r_sel;
      end
   end

   assign out_valid = w_valid;
   assign gnt       = r_gnt;
   assign sel       = r_sel;
   assign busy      = r_busy;

   // Arbitration FSM with registered grant, select and busy outputs.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sel   <= 2'd0;
         r_last  <= 2'd3;
         r_cnt   <= '0;
         r_gnt   <= 4'b0000;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_idle_pick[2]) begin
                  r_state <= ST_GRANT;
                  r_sel   <= w_idle_pick[1:0];
                  r_gnt   <= 4'b0001 << w_idle_pick[1:0];
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            ST_GRANT: begin
               if (w_exit) begin
                  r_last <= r_sel;
                  r_cnt  <= '0;
                  if (w_grant_pick[2]) begin
                     r_sel <= w_grant_pick[1:0];
                     r_gnt <= 4'b0001 << w_grant_pick[1:0];
                  end else begin
                     r_state <= ST_IDLE;
                     r_gnt   <= 4'b0000;
                     r_busy  <= 1'b0;
                  end
               end else if (w_xfer) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= 4'b0000;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_4to1_rr_arbiter
// Two instances (BURST_LEN=4 and BURST_LEN=1) share all inputs. A behavioural
// model tracks "who holds the grant, how many beats accepted, who won last"
// for each instance and every output is compared on each falling edge.
// Directed scenarios add literal expectations; a random phase follows.
// ----------------------------------------------------------------------------
module tb_mux_4to1_rr_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [W-1:0] a, b, c, d;
   logic         out_ready;

   logic [3:0]   o_gnt  [2];
   logic [3:0]   o_ack  [2];
   logic [1:0]   o_sel  [2];
   logic [W-1:0] o_out  [2];
   logic         o_val  [2];
   logic         o_busy [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_4to1_rr_arbiter #(.WIDTH(W), .BURST_LEN(4)) dut4 (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
      .out_ready(out_ready), .gnt(o_gnt[0]), .ack(o_ack[0]), .sel(o_sel[0]),
      .out(o_out[0]), .out_valid(o_val[0]), .busy(o_busy[0]));

   mux_4to1_rr_arbiter #(.WIDTH(W), .BURST_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
      .out_ready(out_ready), .gnt(o_gnt[1]), .ack(o_ack[1]), .sel(o_sel[1]),
      .out(o_out[1]), .out_valid(o_val[1]), .busy(o_busy[1]));

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int holding;   // 1 while some requester owns the grant
      int owner;     // index of granted requester (kept after release)
      int beats;     // accepted transfers in the current grant
      int last;      // most recent winner
   } arb_t;

   arb_t m [2];

   function automatic int burst_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   // Nearest requester strictly after 'base' going round the ring;
   // 'base' itself is considered last.
   function automatic int next_after(input int base, input logic [3:0] r);
      for (int i = 1; i <= 4; i++) begin
         if (r[(base + i) % 4]) return (base + i) % 4;
      end
      return -1;
   endfunction

   function automatic arb_t advance(input arb_t s, input int blen,
                                    input logic [3:0] r, input logic rdy);
      arb_t n;
      int   w;
      bit   took, done;
      n = s;
      if (s.holding == 0) begin
         w = next_after(s.last, r);
         if (w >= 0) begin
            n.holding = 1;
            n.owner   = w;
            n.beats   = 0;
         end
      end else begin
         took = r[s.owner] && rdy;
         done = !r[s.owner] || (took && (s.beats + 1 == blen));
         if (took) n.beats = s.beats + 1;
         if (done) begin
            n.last  = s.owner;
            n.beats = 0;
            w = next_after(s.owner, r);
            if (w >= 0) n.owner = w;
            else        n.holding = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [W-1:0] data_of(input int s);
      case (s)
         0:       return a;
         1:       return b;
         2:       return c;
         default: return d;
      endcase
   endfunction

   // Model state follows the same clock and asynchronous reset as the DUT.
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) m[k] <= '{holding: 0, owner: 0, beats: 0, last: 3};
         else     m[k] <= advance(m[k], burst_of(k), req, out_ready);
      end
   end

   // Compare every output of both instances on each falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [3:0]   e_gnt, e_ack;
         logic [W-1:0] e_out;
         logic         e_val;
         string        p;
         p     = (k == 0) ? "bl4" : "bl1";
         e_gnt = (m[k].holding != 0) ? (4'b0001 << m[k].owner) : 4'b0000;
         e_val = (m[k].holding != 0) && req[m[k].owner];
         e_out = (m[k].holding != 0) ? data_of(m[k].owner) : '0;
         e_ack = (e_val && out_ready) ? (4'b0001 << m[k].owner) : 4'b0000;
         check({p, " gnt"},  32'(o_gnt[k]),  32'(e_gnt));
         check({p, " busy"}, 32'(o_busy[k]), 32'(m[k].holding != 0));
         check({p, " sel"},  32'(o_sel[k]),  32'(m[k].owner));
         check({p, " valid"},32'(o_val[k]),  32'(e_val));
         check({p, " out"},  32'(o_out[k]),  32'(e_out));
         check({p, " ack"},  32'(o_ack[k]),  32'(e_ack));
      end
   end

   // Reset pulse; returns at posedge+1 with reset released.
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
      a = 4'd1; b = 4'd2; c = 4'd4; d = 4'd8;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] seq [5];
      rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
      a = 4'd1; b = 4'd2; c = 4'd4; d = 4'd8;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset gnt",  32'(o_gnt[0]),  32'h0);
      check("reset busy", 32'(o_busy[0]), 32'h0);
      check("reset sel",  32'(o_sel[0]),  32'h0);
      check("reset out",  32'(o_out[0]),  32'h0);

      // 1: single requester 1, full-rate, regranted after burst end
      do_reset();
      req = 4'b0010; out_ready = 1'b1;
      @(negedge clk);
      check("t1 gnt before edge", 32'(o_gnt[0]), 32'h0);
      @(negedge clk);
      check("t1 gnt", 32'(o_gnt[0]), 32'h2);
      check("t1 out", 32'(o_out[0]), 32'h2);
      check("t1 ack", 32'(o_ack[0]), 32'h2);
      repeat (5) @(negedge clk);
      check("t1 gnt after burst", 32'(o_gnt[0]), 32'h2);
      check("t1 ack after burst", 32'(o_ack[0]), 32'h2);

      // 2: all request, rotation 0,1,2,3,0 every 4 cycles
      do_reset();
      req = 4'b1111; out_ready = 1'b1;
      seq = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (i % 4 == 0) check("t2 out", 32'(o_out[0]), 32'(seq[i / 4]));
      end

      // 3: backpressure after 2 transfers, then 2 more acks
      do_reset();
      req = 4'b0001; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3 stall valid", 32'(o_val[0]), 32'h1);
         check("t3 stall ack",   32'(o_ack[0]), 32'h0);
         check("t3 stall out",   32'(o_out[0]), 32'h1);
         @(posedge clk);
      end
      #1 out_ready = 1'b1;
      @(negedge clk); check("t3 ack 3", 32'(o_ack[0]), 32'h1);
      @(negedge clk); check("t3 ack 4", 32'(o_ack[0]), 32'h1);

      // 4: requester 0 drops after 2 acks, requester 3 follows, then idle
      do_reset();
      req = 4'b1001; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 req = 4'b1000;
      @(negedge clk);
      check("t4 drop valid", 32'(o_val[0]), 32'h0);
      check("t4 drop gnt",   32'(o_gnt[0]), 32'h1);
      @(negedge clk);
      check("t4 next gnt", 32'(o_gnt[0]), 32'h8);
      check("t4 next out", 32'(o_out[0]), 32'h8);
      @(posedge clk); #1 req = 4'b0000;
      @(posedge clk); @(negedge clk);
      check("t4 idle gnt", 32'(o_gnt[0]), 32'h0);
      check("t4 idle out", 32'(o_out[0]), 32'h0);

      // 5: asynchronous reset mid-burst on grant 2
      do_reset();
      req = 4'b0100; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t5 async gnt",   32'(o_gnt[0]), 32'h0);
      check("t5 async valid", 32'(o_val[0]), 32'h0);
      check("t5 async sel",   32'(o_sel[0]), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; req = 4'b0110;
      @(posedge clk); @(negedge clk);
      check("t5 first gnt", 32'(o_gnt[0]), 32'h2);

      // 6: BURST_LEN=1 alternates 0,2 every cycle
      do_reset();
      req = 4'b0101; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         check("t6 gnt", 32'(o_gnt[1]), (i % 2 == 0) ? 32'h1 : 32'h4);
         check("t6 out", 32'(o_out[1]), (i % 2 == 0) ? 32'h1 : 32'h4);
      end

      // Random phase, checked by the model on every falling edge
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) req = 4'($urandom);
         out_ready = ($urandom_range(3) != 0);
         if ($urandom_range(7) == 0) begin
            a = 4'($urandom); b = 4'($urandom);
            c = 4'($urandom); d = 4'($urandom);
         end
         if ($urandom_range(199) == 0) begin
            #2 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
